// File: rtl/alu_seq_if.sv
// Execute-stage ALU bundle: operands and op code in,
// registered result plus start/busy/done handshake out.
interface alu_seq_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [3:0]        Operation;
  logic [DATA_W-1:0] SrcA;
  logic [DATA_W-1:0] SrcB;
  logic [DATA_W-1:0] ALUResult;
  logic              Zero;
  logic              busy;
  logic              done;

  modport master (
    output start, Operation, SrcA, SrcB,
    input  ALUResult, Zero, busy, done
  );

  modport slave (
    input  start, Operation, SrcA, SrcB,
    output ALUResult, Zero, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith/compare,
// iterative one-bit-per-cycle shifter for SLL/SRL/SRA.
module alu_seq #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input logic   clk,
  input logic   reset,
  alu_seq_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  work, work_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] shamt;
  logic [3:0]         op;
  logic [DATA_W-1:0]  alu_val;
  logic [DATA_W-1:0]  result;
  logic               zero;
  logic               is_shift;
  logic               go_shift;
  logic               last;
  logic               unused;

  assign shamt    = bus.SrcB[SHAMT_W-1:0];
  assign unused   = ^bus.SrcB[DATA_W-1:SHAMT_W];
  assign is_shift = (bus.Operation == OP_SLL)
                 || (bus.Operation == OP_SRL)
                 || (bus.Operation == OP_SRA);
  assign go_shift = is_shift && (shamt != '0);
  assign last     = (cnt == SHAMT_W'(1));

  always_comb begin
    alu_val = '0;
    case (bus.Operation)
      OP_AND:  alu_val = bus.SrcA & bus.SrcB;
      OP_OR:   alu_val = bus.SrcA | bus.SrcB;
      OP_ADD:  alu_val = bus.SrcA + bus.SrcB;
      OP_SUB:  alu_val = bus.SrcA - bus.SrcB;
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_val = bus.SrcA;
      OP_EQ:   alu_val = DATA_W'(bus.SrcA == bus.SrcB);
      OP_SLT:  alu_val = DATA_W'($signed(bus.SrcA)
                                 < $signed(bus.SrcB));
      default: alu_val = '0;
    endcase
  end

  always_comb begin
    work_nxt = work;
    case (op)
      OP_SLL:  work_nxt = {work[DATA_W-2:0], 1'b0};
      OP_SRL:  work_nxt = {1'b0, work[DATA_W-1:1]};
      OP_SRA:  work_nxt = {work[DATA_W-1], work[DATA_W-1:1]};
      default: work_nxt = work;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (bus.start)
          state_nxt = go_shift ? SHIFT : DONE;
      SHIFT:
        if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // The visible result only moves at a result load,
  // never with the intermediate working register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work   <= '0;
      cnt    <= '0;
      op     <= '0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE:
          if (bus.start) begin
            if (go_shift) begin
              work <= bus.SrcA;
              cnt  <= shamt;
              op   <= bus.Operation;
            end else begin
              result <= alu_val;
              zero   <= (alu_val == '0);
            end
          end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - SHAMT_W'(1);
          if (last) begin
            result <= work_nxt;
            zero   <= (work_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ALUResult = result;
  assign bus.Zero      = zero;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq:
// per-feature tasks with hand-computed expectations.
module tb_alu_seq;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  alu_seq_if #(.DATA_W(32)) bus();

  alu_seq #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request for one cycle, then scramble inputs.
  // Returns at the negedge in the cycle after E0.
  task automatic issue(input logic [3:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.Operation = o;
    bus.SrcA      = a;
    bus.SrcB      = b;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.Operation = 4'b0011;
    bus.SrcA      = 32'h5A5A_A5A5;
    bus.SrcB      = 32'h0000_0003;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: res=%h z=%b busy=%b done=%b exp 0/1/0/0",
               bus.ALUResult, bus.Zero, bus.busy, bus.done);
    end
    reset = 1'b0;
  endtask

  task automatic test_add_sub();
    issue(4'b0010, 32'hFFFF_FFFF, 32'h1);
    n_chk++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 ||
        bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap: done=%b busy=%b res=%h z=%b exp 1/1/0/1",
               bus.done, bus.busy, bus.ALUResult, bus.Zero);
    end
    @(negedge clk);
    n_chk++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
        bus.ALUResult !== 32'h0) begin
      n_fail++;
      $display("FAIL add_after: done=%b busy=%b res=%h exp 0/0/0",
               bus.done, bus.busy, bus.ALUResult);
    end
    issue(4'b0011, 32'd5, 32'd7);
    n_chk++;
    if (bus.done !== 1'b1 || bus.ALUResult !== 32'hFFFF_FFFE ||
        bus.Zero !== 1'b0) begin
      n_fail++;
      $display("FAIL sub: done=%b res=%h z=%b exp 1/fffffffe/0",
               bus.done, bus.ALUResult, bus.Zero);
    end
  endtask

  task automatic test_compare();
    logic [3:0]  ops [4] = '{4'b1100, 4'b1000, 4'b1000, 4'b1111};
    logic [31:0] as  [4] = '{32'h8000_0000, 32'h1234, 32'h1, 32'h5};
    logic [31:0] bs  [4] = '{32'h1, 32'h1234, 32'h2, 32'h3};
    logic [31:0] er  [4] = '{32'h1, 32'h1, 32'h0, 32'h0};
    logic        ez  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_chk++;
      if (bus.done !== 1'b1 || bus.ALUResult !== er[i] ||
          bus.Zero !== ez[i]) begin
        n_fail++;
        $display("FAIL cmp%0d op=%b: done=%b res=%h z=%b exp 1/%h/%b",
                 i, ops[i], bus.done, bus.ALUResult, bus.Zero,
                 er[i], ez[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_shift();
    logic [3:0]  ops [3] = '{4'b0111, 4'b0101, 4'b0100};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'h1};
    logic [31:0] bs  [3] = '{32'd4, 32'd4, 32'd31};
    logic [31:0] er  [3] = '{32'hF800_0000, 32'h0800_0000,
                             32'h8000_0000};
    int          k   [3] = '{4, 4, 31};
    logic [31:0] prev;
    int          cyc;
    logic        held;
    prev = 32'h0;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      cyc  = 0;
      held = 1'b1;
      while (bus.done !== 1'b1 && cyc < 40) begin
        if (bus.ALUResult !== prev || bus.busy !== 1'b1) held = 1'b0;
        @(negedge clk);
        cyc++;
      end
      n_chk++;
      if (cyc != k[i]) begin
        n_fail++;
        $display("FAIL shift%0d latency: %0d cycles exp %0d",
                 i, cyc, k[i]);
      end
      n_chk++;
      if (!held) begin
        n_fail++;
        $display("FAIL shift%0d hold: result/busy moved during SHIFT, exp %h/1",
                 i, prev);
      end
      n_chk++;
      if (bus.ALUResult !== er[i] || bus.Zero !== 1'b0) begin
        n_fail++;
        $display("FAIL shift%0d result: %h z=%b exp %h z=0",
                 i, bus.ALUResult, bus.Zero, er[i]);
      end
      prev = er[i];
      @(negedge clk);
    end
  endtask

  task automatic test_shamt0();
    issue(4'b0100, 32'hDEAD_BEEF, 32'h20);
    n_chk++;
    if (bus.done !== 1'b1 || bus.ALUResult !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL shamt0: done=%b res=%h exp 1/deadbeef",
               bus.done, bus.ALUResult);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_start();
    int cyc;
    int pulses;
    issue(4'b0100, 32'h3, 32'd8);
    bus.start     = 1'b1;
    bus.Operation = 4'b0010;
    bus.SrcA      = 32'h1;
    bus.SrcB      = 32'h1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (cyc != 8 || bus.ALUResult !== 32'h300) begin
      n_fail++;
      $display("FAIL busy_sll: cyc=%0d res=%h exp 8/00000300",
               cyc, bus.ALUResult);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses != 0 || bus.busy !== 1'b0 ||
        bus.ALUResult !== 32'h300) begin
      n_fail++;
      $display("FAIL busy_ignore: extra done=%0d busy=%b res=%h exp 0/0/00000300",
               pulses, bus.busy, bus.ALUResult);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_chk++;
    if (bus.done !== 1'b1 || bus.ALUResult !== 32'h2) begin
      n_fail++;
      $display("FAIL busy_next_add: done=%b res=%h exp 1/00000002",
               bus.done, bus.ALUResult);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(4'b0001, 32'hF0, 32'h0F);
    bus.start     = 1'b1;
    bus.Operation = 4'b0000;
    bus.SrcA      = 32'hF0;
    bus.SrcB      = 32'h3C;
    n_chk++;
    if (bus.done !== 1'b1 || bus.ALUResult !== 32'hFF) begin
      n_fail++;
      $display("FAIL b2b_or: done=%b res=%h exp 1/000000ff",
               bus.done, bus.ALUResult);
    end
    @(negedge clk);
    n_chk++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: done=%b busy=%b exp 0/0",
               bus.done, bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_chk++;
    if (bus.done !== 1'b1 || bus.ALUResult !== 32'h30) begin
      n_fail++;
      $display("FAIL b2b_and: done=%b res=%h exp 1/00000030",
               bus.done, bus.ALUResult);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    issue(4'b0101, 32'hFFFF_0000, 32'd20);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b res=%h z=%b exp 0/0/0/1",
               bus.busy, bus.done, bus.ALUResult, bus.Zero);
    end
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d busy/done cycles exp 0",
               pulses);
    end
    issue(4'b0001, 32'hF0, 32'h0F);
    n_chk++;
    if (bus.done !== 1'b1 || bus.ALUResult !== 32'hFF ||
        bus.Zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_next: done=%b res=%h z=%b exp 1/000000ff/0",
               bus.done, bus.ALUResult, bus.Zero);
    end
    @(negedge clk);
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.Operation = 4'b0000;
    bus.SrcA      = 32'h0;
    bus.SrcB      = 32'h0;
    test_reset();
    test_add_sub();
    test_compare();
    test_shift();
    test_shamt0();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, exp finish");
    $fatal(1);
  end
endmodule
